// File: rtl/counter_n_digit_pkg.sv
// Shared constants and helpers for the N-digit up/down counter.
package counter_pkg;

  // Width of one counter digit (one hex or BCD nibble).
  localparam int DIGIT_W    = 4;
  // Largest value a decimal digit may hold.
  localparam int BCD_MAX    = 9;
  // Largest value a hex digit may hold.
  localparam int HEX_MAX    = 15;
  // Largest supported DIGITS value (32-bit count).
  localparam int MAX_DIGITS = 8;

  // Clamp one nibble into the decimal digit range.
  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
    logic [DIGIT_W-1:0] max_d;
    max_d = DIGIT_W'(BCD_MAX);
    return (d > max_d) ? max_d : d;
  endfunction

endpackage

// File: rtl/counter_n_digit_digit.sv
// One 4-bit counter digit: steps up or down when i_step is set and reports
// carry (up) or borrow (down) to the next more significant digit.
module counter_digit
  import counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic               i_step,
  input  logic               i_up,
  input  logic               i_bcd,
  output logic [DIGIT_W-1:0] o_next,
  output logic               o_carry
);

  logic [DIGIT_W-1:0] w_max;

  // Digit roll point depends on the number base.
  assign w_max = i_bcd ? DIGIT_W'(BCD_MAX) : DIGIT_W'(HEX_MAX);

  // Increment/decrement with carry/borrow out at the digit roll point.
  always_comb begin
    o_next  = i_digit;
    o_carry = 1'b0;
    if (i_step) begin
      if (i_up) begin
        if (i_digit >= w_max) begin
          o_next  = '0;
          o_carry = 1'b1;
        end else begin
          o_next  = i_digit + DIGIT_W'(1);
        end
      end else begin
        if (i_digit == '0) begin
          o_next  = w_max;
          o_carry = 1'b1;
        end else begin
          o_next  = i_digit - DIGIT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/counter_n_digit.sv
// N-digit binary/BCD up/down counter with load, enable, programmable upper
// bound (lower bound 0), wrap/saturate select, terminal flag and rollover pulse.
//
// Control is level-sampled on each rising edge: clear (async) beats load,
// load beats enable; with none active the count holds. There is no
// handshake: every input is taken as-is on the edge it is present.
//
// DIGITS must lie in 1..MAX_DIGITS.
module counter_n_digit
  import counter_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int BCD    = 0
) (
  input  logic                      i_clk,
  input  logic                      i_clear,
  input  logic                      i_enable,
  input  logic                      i_up_down,
  input  logic                      i_load,
  input  logic                      i_wrap,
  input  logic [DIGIT_W*DIGITS-1:0] i_data,
  input  logic [DIGIT_W*DIGITS-1:0] i_limit,
  output logic [DIGIT_W*DIGITS-1:0] o_count,
  output logic                      o_terminal,
  output logic                      o_rollover
);

  localparam int   W     = DIGIT_W * DIGITS;
  localparam logic L_BCD = (BCD != 0);

  logic [W-1:0]    r_count;
  logic            r_rollover;

  logic [DIGITS:0] w_chain;
  logic [W-1:0]    w_step;
  logic [W-1:0]    w_load_sat;
  logic [W-1:0]    w_load_val;
  logic            w_at_upper;
  logic            w_at_zero;
  logic            w_ovf;
  logic [W-1:0]    w_next;
  logic            w_wrap_evt;

  // Least significant digit always steps; higher digits step on carry/borrow.
  assign w_chain[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      counter_digit u_digit (
        .i_digit (r_count[g*DIGIT_W +: DIGIT_W]),
        .i_step  (w_chain[g]),
        .i_up    (i_up_down),
        .i_bcd   (L_BCD),
        .o_next  (w_step[g*DIGIT_W +: DIGIT_W]),
        .o_carry (w_chain[g+1])
      );

      // In decimal mode an out-of-range loaded digit is stored as 9.
      assign w_load_sat[g*DIGIT_W +: DIGIT_W] =
        L_BCD ? bcd_sat(i_data[g*DIGIT_W +: DIGIT_W])
              : i_data[g*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  // Loaded value never exceeds the upper bound.
  assign w_load_val = (w_load_sat > i_limit) ? i_limit : w_load_sat;

  assign w_at_upper = (r_count >= i_limit);
  assign w_at_zero  = (r_count == '0);

  // Ripple overflow out of the top digit on an up step. This only happens
  // below the bound in decimal mode when the limit is above all-nines; the
  // all-nines value is then the effective ceiling.
  assign w_ovf = i_up_down & w_chain[DIGITS];

  // Terminal: the next enabled step would cross a bound.
  assign o_terminal = i_enable & ~i_load &
                      ((i_up_down & w_at_upper) | (~i_up_down & w_at_zero));

  // Next-count selection: load, ripple step, or wrap/saturate at a bound.
  always_comb begin
    w_next     = r_count;
    w_wrap_evt = 1'b0;
    if (i_load) begin
      w_next = w_load_val;
    end else if (i_enable) begin
      if (i_up_down) begin
        if (w_at_upper || w_ovf) begin
          if (i_wrap) begin
            w_next     = '0;
            w_wrap_evt = 1'b1;
          end else if (w_at_upper) begin
            w_next = i_limit;
          end else begin
            w_next = r_count;
          end
        end else begin
          w_next = w_step;
        end
      end else begin
        if (w_at_zero) begin
          if (i_wrap) begin
            w_next     = i_limit;
            w_wrap_evt = 1'b1;
          end
        end else begin
          w_next = w_step;
        end
      end
    end
  end

  // Count and rollover registers; clear aborts any step immediately.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_count    <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_count    <= w_next;
      r_rollover <= w_wrap_evt;
    end
  end

  assign o_count    = r_count;
  assign o_rollover = r_rollover;

endmodule

// File: tb/tb_counter_n_digit.sv
// Directed bench for counter_n_digit: one decimal 3-digit instance and one
// binary 8-digit instance. The driver pushes hand-computed expectations into
// a queue; a separate monitor pops and compares them against the outputs.
module tb_counter_n_digit;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // decimal instance (DIGITS=3, BCD=1)
  logic        c0_clr, c0_en, c0_up, c0_ld, c0_wr;
  logic [11:0] c0_data, c0_limit, c0_cnt;
  logic        c0_term, c0_roll;
  // binary instance (DIGITS=8, BCD=0)
  logic        c1_clr, c1_en, c1_up, c1_ld, c1_wr;
  logic [31:0] c1_data, c1_limit, c1_cnt;
  logic        c1_term, c1_roll;

  counter_n_digit #(.DIGITS(3), .BCD(1)) u_dut_bcd (
    .i_clk(clk), .i_clear(c0_clr), .i_enable(c0_en), .i_up_down(c0_up),
    .i_load(c0_ld), .i_wrap(c0_wr), .i_data(c0_data), .i_limit(c0_limit),
    .o_count(c0_cnt), .o_terminal(c0_term), .o_rollover(c0_roll)
  );

  counter_n_digit #(.DIGITS(8), .BCD(0)) u_dut_bin (
    .i_clk(clk), .i_clear(c1_clr), .i_enable(c1_en), .i_up_down(c1_up),
    .i_load(c1_ld), .i_wrap(c1_wr), .i_data(c1_data), .i_limit(c1_limit),
    .o_count(c1_cnt), .o_terminal(c1_term), .o_rollover(c1_roll)
  );

  // ---------------- scoreboard ----------------
  logic [33:0] exp_q[$];   // {rollover, terminal, count}
  int          sel_q[$];
  string       name_q[$];
  event        chk_now;
  int          checks = 0;
  int          errors = 0;

  task automatic push_exp(input int sel, input logic [31:0] cnt,
                          input logic term, input logic roll, input string nm);
    exp_q.push_back({roll, term, cnt});
    sel_q.push_back(sel);
    name_q.push_back(nm);
    -> chk_now;
  endtask

  // monitor: drain all pending expectations whenever the driver posts one
  initial begin
    logic [33:0] e;
    logic [33:0] act;
    int          s;
    string       n;
    forever begin
      @(chk_now);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        s = sel_q.pop_front();
        n = name_q.pop_front();
        if (s == 0) act = {c0_roll, c0_term, 20'd0, c0_cnt};
        else        act = {c1_roll, c1_term, c1_cnt};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got cnt=%h term=%b roll=%b, expected cnt=%h term=%b roll=%b",
                   n, act[31:0], act[32], act[33], e[31:0], e[32], e[33]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits a little so the monitor has sampled before inputs change.
  task automatic set(input int sel, input logic en, input logic up,
                     input logic ld, input logic wr,
                     input logic [31:0] d, input logic [31:0] l);
    #2;
    if (sel == 0) begin
      c0_en = en; c0_up = up; c0_ld = ld; c0_wr = wr;
      c0_data = d[11:0]; c0_limit = l[11:0];
    end else begin
      c1_en = en; c1_up = up; c1_ld = ld; c1_wr = wr;
      c1_data = d; c1_limit = l;
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    c0_clr = 1'b1; c0_en = 0; c0_up = 0; c0_ld = 0; c0_wr = 0; c0_data = '0; c0_limit = '0;
    c1_clr = 1'b1; c1_en = 0; c1_up = 0; c1_ld = 0; c1_wr = 0; c1_data = '0; c1_limit = '0;
    #1;
    push_exp(0, 0, 0, 0, "reset_bcd");
    push_exp(1, 0, 0, 0, "reset_bin");
    #2;
    c0_clr = 1'b0;
    c1_clr = 1'b0;

    // binary: terminal from reset values, saturating down at 0
    set(1, 1, 0, 0, 0, 0, 'hFF);
    push_exp(1, 0, 1, 0, "term_from_reset");
    for (int i = 0; i < 3; i++) begin
      tick(); push_exp(1, 0, 1, 0, "sat_down_zero");
    end

    // load clamp to limit, then wrap up
    set(1, 0, 1, 1, 1, 'h20, 'h0A); tick(); push_exp(1, 'h0A, 0, 0, "load_clamp_0a");
    set(1, 1, 1, 0, 1, 'h20, 'h0A); tick(); push_exp(1, 'h00, 0, 1, "wrap_up_0a");
    set(1, 0, 1, 0, 1, 'h00, 'h0A); tick(); push_exp(1, 'h00, 0, 0, "rollover_one_cycle");

    // load beats enable
    set(1, 1, 1, 1, 0, 'h05, 'hFF); tick(); push_exp(1, 'h05, 0, 0, "load_over_enable");

    // multi-digit borrow
    set(1, 0, 0, 1, 0, 'h1000, 'hFFFFFFFF); tick(); push_exp(1, 'h1000, 0, 0, "load_1000");
    set(1, 1, 0, 0, 0, 'h1000, 'hFFFFFFFF); tick(); push_exp(1, 'h0FFF, 0, 0, "borrow_0fff");

    // full 32-bit wrap in both directions
    set(1, 0, 1, 1, 1, 'hFFFFFFFE, 'hFFFFFFFF); tick(); push_exp(1, 'hFFFFFFFE, 0, 0, "load_fffffffe");
    set(1, 1, 1, 0, 1, 'hFFFFFFFE, 'hFFFFFFFF); tick(); push_exp(1, 'hFFFFFFFF, 1, 0, "up_to_max");
    tick(); push_exp(1, 'h00000000, 0, 1, "wrap_32bit");
    set(1, 1, 0, 0, 1, 0, 'hFFFFFFFF); tick(); push_exp(1, 'hFFFFFFFF, 0, 1, "wrap_down_32bit");

    // limit lowered below count mid-count
    set(1, 0, 1, 1, 0, 'h30, 'hFF); tick(); push_exp(1, 'h30, 0, 0, "load_30");
    set(1, 1, 0, 0, 0, 'h30, 'h10); tick(); push_exp(1, 'h2F, 0, 0, "down_above_limit");
    set(1, 1, 1, 0, 0, 'h30, 'h10); tick(); push_exp(1, 'h10, 1, 0, "sat_up_to_limit");

    // limit = 0
    set(1, 0, 1, 1, 1, 0, 0); tick(); push_exp(1, 0, 0, 0, "load_lim0");
    set(1, 1, 1, 0, 1, 0, 0); tick(); push_exp(1, 0, 1, 1, "lim0_up_wrap_a");
    tick(); push_exp(1, 0, 1, 1, "lim0_up_wrap_b");
    set(1, 1, 0, 0, 1, 0, 0); tick(); push_exp(1, 0, 1, 1, "lim0_down_wrap");
    set(1, 1, 1, 0, 0, 0, 0); tick(); push_exp(1, 0, 1, 0, "lim0_up_sat");
    set(1, 0, 1, 0, 0, 0, 0);

    // decimal: 58 -> 59 -> 00 with rollover
    set(0, 0, 1, 1, 1, 'h058, 'h059); tick(); push_exp(0, 'h058, 0, 0, "bcd_load_58");
    set(0, 1, 1, 0, 1, 'h058, 'h059); tick(); push_exp(0, 'h059, 1, 0, "bcd_up_59");
    tick(); push_exp(0, 'h000, 0, 1, "bcd_wrap_00");
    set(0, 0, 1, 0, 1, 0, 'h059); tick(); push_exp(0, 'h000, 0, 0, "bcd_roll_clear");
    set(0, 1, 0, 0, 1, 0, 'h059); tick(); push_exp(0, 'h059, 0, 1, "bcd_wrap_down");

    // decimal borrow and digit saturation on load
    set(0, 0, 1, 1, 0, 'h100, 'h999); tick(); push_exp(0, 'h100, 0, 0, "bcd_load_100");
    set(0, 1, 0, 0, 0, 'h100, 'h999); tick(); push_exp(0, 'h099, 0, 0, "bcd_borrow_099");
    set(0, 0, 0, 1, 0, 'h3A7, 'h999); tick(); push_exp(0, 'h397, 0, 0, "bcd_load_3a7");
    set(0, 0, 0, 1, 0, 'h999, 'h500); tick(); push_exp(0, 'h500, 0, 0, "bcd_load_clamp");
    set(0, 0, 0, 1, 0, 'h0F0, 'h050); tick(); push_exp(0, 'h050, 0, 0, "bcd_sat_then_clamp");
    set(0, 0, 1, 1, 0, 'h199, 'h999); tick(); push_exp(0, 'h199, 0, 0, "bcd_load_199");
    set(0, 1, 1, 0, 0, 'h199, 'h999); tick(); push_exp(0, 'h200, 0, 0, "bcd_carry_200");
    set(0, 0, 1, 1, 0, 'h005, 'h005); tick(); push_exp(0, 'h005, 0, 0, "bcd_load_5");
    set(0, 1, 1, 0, 0, 'h005, 'h005); tick(); push_exp(0, 'h005, 1, 0, "bcd_sat_up");

    // asynchronous clear between edges while counting
    set(0, 1, 1, 1, 0, 'h037, 'h999); tick(); push_exp(0, 'h037, 0, 0, "bcd_load_37_en");
    #2 c0_ld = 1'b0;
    #1 c0_clr = 1'b1;
    #1 push_exp(0, 'h000, 0, 0, "clear_immediate");
    tick(); push_exp(0, 'h000, 0, 0, "clear_held");
    #2 c0_clr = 1'b0;
    tick(); push_exp(0, 'h001, 0, 0, "resume_1");
    tick(); push_exp(0, 'h002, 0, 0, "resume_2");

    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_n_digit.md
COUNTER_N_DIGIT -- requirements
Module: counter_n_digit

Interface
REQ-001 Parameter DIGITS, default 8, number of 4-bit digits; legal range 1..8.
REQ-002 Parameter BCD, default 0; 0 = binary (hex digits), 1 = decimal (each digit 0..9).
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Clear  input  1  reset, asynchronous, active-high.
REQ-005 Enable  input  1  count step permitted this cycle.
REQ-006 Up_down  input  1  1 = count up, 0 = count down.
REQ-007 Load  input  1  synchronous parallel load.
REQ-008 Wrap  input  1  1 = wrap at bounds, 0 = saturate at bounds.
REQ-009 Data  input  4*DIGITS  load value.
REQ-010 Limit  input  4*DIGITS  programmable upper bound, inclusive; lower bound fixed at 0.
REQ-011 Count  output  4*DIGITS  registered count value.
REQ-012 Terminal  output  1  combinational; next enabled step crosses a bound.
REQ-013 Rollover  output  1  registered one-cycle pulse after a wrap event.

Function
REQ-014 Priority per edge SHALL be Clear > Load > Enable; with none active, Count SHALL hold.
REQ-015 Load SHALL set Count to Data; if Data > Limit (unsigned compare), Count SHALL be Limit instead.
REQ-016 In BCD=1, any loaded digit > 9 SHALL be stored as 9 before the Limit clamp.
REQ-017 Up step with Count < Limit: Count+1 (binary), or decimal increment with digit carry (BCD=1).
REQ-018 Up step with Count >= Limit: Wrap=1 -> Count = 0; Wrap=0 -> Count = Limit.
REQ-019 Down step with Count > 0: Count-1 (binary), or decimal decrement with digit borrow (BCD=1); Count > Limit decrements normally.
REQ-020 Down step with Count = 0: Wrap=1 -> Count = Limit; Wrap=0 -> Count holds 0.
REQ-021 Terminal SHALL equal Enable & !Load & ((Up_down & Count >= Limit) | (!Up_down & Count == 0)).
REQ-022 Rollover SHALL be 1 for exactly the cycle after an edge where a Wrap=1 bound transition (REQ-018/020) occurred, else 0; saturating holds SHALL NOT assert it.
REQ-023 Limit = 0: up and down steps SHALL leave Count at 0; Wrap=1 steps SHALL pulse Rollover every enabled cycle.
REQ-024 Limit and Wrap SHALL be sampled on the same edge as the step; changing either mid-count SHALL take effect on the next edge with no other side effect.
REQ-025 Step latency SHALL be one clock: Count reflects the step on the edge where Enable is sampled high.
REQ-026 DIGITS=8, BCD=0, Limit=FFFFFFFF SHALL behave as a plain 32-bit up/down counter with load and enable.

Reset
REQ-027 Clear high SHALL immediately force Count = 0 and Rollover = 0 regardless of Clock.
REQ-028 Clear asserted mid-count SHALL abort the step; after release, the first edge SHALL act on inputs only (no pending step or pulse).
REQ-029 Terminal SHALL follow REQ-021 from reset values (Count = 0).

Structure
REQ-030 Shared package counter_pkg SHALL hold DIGIT_W = 4, BCD_MAX = 9, HEX_MAX = 15, and MAX_DIGITS = 8.
REQ-031 One sub-module counter_digit (one 4-bit digit: step-in, up/down, BCD select, carry/borrow-out, next value) SHALL be instantiated DIGITS times in a ripple chain.
REQ-032 Bound compare, load clamp, and wrap/saturate selection SHALL reside in counter_n_digit.

Verification
REQ-033 BCD=1, DIGITS=2, Limit=59, Wrap=1, Count=58, up x2 -> Count 59 then 00; Rollover high one cycle after second edge.
REQ-034 BCD=0, DIGITS=2, Limit=FF, Wrap=0, Count=00, down x3 -> Count stays 00; Terminal=1; Rollover stays 0.
REQ-035 BCD=1, DIGITS=3, Count=100, down x1 -> 099; then Load with Data=3A7, Limit=999 -> 397.
REQ-036 BCD=0, Limit=0A, Load Data=20 -> Count 0A; up with Wrap=1 -> 00 and Rollover pulse.
REQ-037 Load and Enable both high with Data=05 -> Count 05 (no step applied).
REQ-038 Clear pulsed mid-cycle between edges while Count=37 and Enable=1 -> Count 0 immediately, Rollover 0, counting resumes from 0 after release.
